fft_r4_copro: RTL and testbench

- Memory-mapped radix-4 FFT butterfly coprocessor on the openMSP430 peripheral bus.
- Software loads four complex operands and up to three complex twiddles, then writes START.
- An FSM applies the twiddles through one shared complex multiplier, runs the radix-4 butterfly with selectable output scaling and saturation, and flags completion by status bit and interrupt.
- Successor to the fixed combinational four-butterfly block. Adds parametrised width, twiddle multiply, scaling, overflow detection and handshake.

---
 rtl/fft_r4_copro.sv | 203 ++++++++++++++++++++
 tb/tb_fft_r4_copro.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_r4_copro.sv
// Radix-4 FFT butterfly coprocessor on the openMSP430 peripheral bus.
// Optional twiddles pass through one shared complex multiplier, one per cycle, before the butterfly.
module fft_r4_copro #(
    parameter int          DW        = 16,
    parameter logic [13:0] BASE_ADDR = 14'h0088
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic        irq
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TW1  = 3'd1;
    localparam logic [2:0] S_TW2  = 3'd2;
    localparam logic [2:0] S_TW3  = 3'd3;
    localparam logic [2:0] S_SUM  = 3'd4;

    localparam logic signed [DW-1:0] Q_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] Q_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [2*DW:0] RND   = {{(DW+2){1'b0}}, 1'b1, {(DW-2){1'b0}}};

    logic [2:0]           state;
    logic signed [DW-1:0] opnd [8];
    logic signed [DW-1:0] tw   [6];
    logic signed [DW-1:0] twd  [6];   // B', C', D' as (re, im) pairs
    logic signed [DW-1:0] res  [8];
    logic                 tw_en, irq_en, done, ovf;
    logic [1:0]           shift;

    logic [13:0] offset;
    logic [4:0]  sel;
    logic        in_span, wr_en, busy, start;

    assign offset  = per_addr - BASE_ADDR;
    assign in_span = (offset < 14'd32);
    assign sel     = offset[4:0];
    assign busy    = (state != S_IDLE);
    assign wr_en   = per_en && in_span && (per_we == 2'b11);
    assign start   = wr_en && (sel == 5'h0E) && per_din[0] && !busy;
    assign irq     = done & irq_en;

    function automatic logic signed [2*DW:0] sx_m(input logic signed [DW-1:0] v);
        return {{(DW+1){v[DW-1]}}, v};
    endfunction

    function automatic logic signed [DW+1:0] sx_b(input logic signed [DW-1:0] v);
        return {{2{v[DW-1]}}, v};
    endfunction

    function automatic logic fits_m(input logic signed [2*DW:0] v);
        return (v[2*DW:DW-1] == '0) || (v[2*DW:DW-1] == '1);
    endfunction

    function automatic logic signed [DW-1:0] sat_m(input logic signed [2*DW:0] v);
        if (fits_m(v))
            return v[DW-1:0];
        return v[2*DW] ? Q_MIN : Q_MAX;
    endfunction

    // Shared multiplier operands follow the twiddle stage being executed.
    logic signed [DW-1:0] mx_r, mx_i, mw_r, mw_i;
    always_comb begin
        mx_r = opnd[2];
        mx_i = opnd[3];
        mw_r = tw[0];
        mw_i = tw[1];
        case (state)
            S_TW2: begin
                mx_r = opnd[4];
                mx_i = opnd[5];
                mw_r = tw[2];
                mw_i = tw[3];
            end
            S_TW3: begin
                mx_r = opnd[6];
                mx_i = opnd[7];
                mw_r = tw[4];
                mw_i = tw[5];
            end
            default: ;
        endcase
    end

    logic signed [2*DW:0] m_re, m_im;
    logic                 mul_sat;
    logic [2:0]           tw_idx;
    assign m_re    = (sx_m(mx_r) * sx_m(mw_r) - sx_m(mx_i) * sx_m(mw_i) + RND) >>> (DW-1);
    assign m_im    = (sx_m(mx_r) * sx_m(mw_i) + sx_m(mx_i) * sx_m(mw_r) + RND) >>> (DW-1);
    assign mul_sat = !fits_m(m_re) || !fits_m(m_im);
    assign tw_idx  = {state[1:0] - 2'd1, 1'b0};

    logic signed [DW+1:0] ar, ai, br, bi, cr, ci, dr, di;
    logic signed [DW+1:0] bf [8];
    logic [1:0]           sh_amt;
    assign sh_amt = (shift == 2'd3) ? 2'd2 : shift;
    assign ar = sx_b(opnd[0]);
    assign ai = sx_b(opnd[1]);
    assign br = sx_b(tw_en ? twd[0] : opnd[2]);
    assign bi = sx_b(tw_en ? twd[1] : opnd[3]);
    assign cr = sx_b(tw_en ? twd[2] : opnd[4]);
    assign ci = sx_b(tw_en ? twd[3] : opnd[5]);
    assign dr = sx_b(tw_en ? twd[4] : opnd[6]);
    assign di = sx_b(tw_en ? twd[5] : opnd[7]);

    always_comb begin
        bf[0] = ar + br + cr + dr;
        bf[1] = ai + bi + ci + di;
        bf[2] = ar + bi - cr - di;
        bf[3] = ai - br - ci + dr;
        bf[4] = ar - br + cr - dr;
        bf[5] = ai - bi + ci - di;
        bf[6] = ar - bi - cr + di;
        bf[7] = ai + br - ci - dr;
    end

    logic signed [DW-1:0] res_next [8];
    logic [7:0]           bf_sat;
    for (genvar gi = 0; gi < 8; gi++) begin : g_sat
        logic signed [DW+1:0] shifted;
        assign shifted       = bf[gi] >>> sh_amt;
        assign bf_sat[gi]    = !((shifted[DW+1:DW-1] == '0) || (shifted[DW+1:DW-1] == '1));
        assign res_next[gi]  = bf_sat[gi] ? (shifted[DW+1] ? Q_MIN : Q_MAX) : shifted[DW-1:0];
    end

    logic signed [DW-1:0] rd_val;
    always_comb begin
        rd_val = '0;
        if (sel < 5'h08)
            rd_val = opnd[sel[2:0]];
        else if (sel < 5'h0E)
            rd_val = tw[sel[2:0]];
        else if (sel == 5'h0E)
            rd_val[4:0] = {irq_en, shift, tw_en, 1'b0};
        else if (sel == 5'h0F)
            rd_val[2:0] = {ovf, done, busy};
        else if (sel < 5'h18)
            rd_val = res[sel[2:0]];
    end
    assign per_dout = (per_en && (per_we == 2'b00) && in_span) ? 16'(rd_val) : 16'h0000;

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state  <= S_IDLE;
            tw_en  <= 1'b0;
            irq_en <= 1'b0;
            shift  <= 2'd0;
            done   <= 1'b0;
            ovf    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                opnd[i] <= '0;
                res[i]  <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                tw[2*i]    <= Q_MAX;
                tw[2*i+1]  <= '0;
                twd[2*i]   <= '0;
                twd[2*i+1] <= '0;
            end
        end else begin
            if (wr_en && !busy) begin
                if (sel < 5'h08)
                    opnd[sel[2:0]] <= per_din[DW-1:0];
                else if (sel < 5'h0E)
                    tw[sel[2:0]] <= per_din[DW-1:0];
                else if (sel == 5'h0E) begin
                    tw_en  <= per_din[1];
                    shift  <= per_din[3:2];
                    irq_en <= per_din[4];
                end
            end
            if (wr_en && (sel == 5'h0F)) begin
                if (per_din[1]) done <= 1'b0;
                if (per_din[2]) ovf  <= 1'b0;
            end
            // Status sets below are placed after the clears so that they win.
            case (state)
                S_IDLE: if (start) begin
                    done  <= 1'b0;
                    ovf   <= 1'b0;
                    state <= per_din[1] ? S_TW1 : S_SUM;
                end
                S_TW1, S_TW2, S_TW3: begin
                    twd[tw_idx]        <= sat_m(m_re);
                    twd[tw_idx + 3'd1] <= sat_m(m_im);
                    if (mul_sat) ovf <= 1'b1;
                    state <= (state == S_TW3) ? S_SUM : state + 3'd1;
                end
                S_SUM: begin
                    for (int i = 0; i < 8; i++)
                        res[i] <= res_next[i];
                    done <= 1'b1;
                    if (|bf_sat) ovf <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_r4_copro.sv
// Bench for fft_r4_copro: directed cases plus randomized operations checked
// against an arithmetic reference of the butterfly and twiddle multiply.
module tb_fft_r4_copro;
    localparam logic [13:0] BASE = 14'h0088;

    logic        mclk     = 1'b0;
    logic        puc_rst  = 1'b1;
    logic [13:0] per_addr = '0;
    logic [15:0] per_din  = '0;
    logic        per_en   = 1'b0;
    logic [1:0]  per_we   = 2'b00;
    logic [15:0] per_dout, per_dout12;
    logic        irq, irq12;

    int total = 0;
    int bad   = 0;

    int   m_op [8];
    int   m_tw [6];
    int   m_x  [8];
    bit   m_tw_en, m_irq_en, m_ovf;
    int   m_sh;
    logic [15:0] rx [8];
    logic [15:0] rd_d, rd_d12;

    always #50 mclk = ~mclk;

    fft_r4_copro #(.DW(16), .BASE_ADDR(BASE)) dut (
        .mclk(mclk), .puc_rst(puc_rst), .per_addr(per_addr), .per_din(per_din),
        .per_en(per_en), .per_we(per_we), .per_dout(per_dout), .irq(irq)
    );

    fft_r4_copro #(.DW(12), .BASE_ADDR(BASE)) dut12 (
        .mclk(mclk), .puc_rst(puc_rst), .per_addr(per_addr), .per_din(per_din),
        .per_en(per_en), .per_we(per_we), .per_dout(per_dout12), .irq(irq12)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic bus_wr(input logic [4:0] off, input logic [15:0] d, input logic [1:0] we);
        per_addr = BASE + 14'(off);
        per_din  = d;
        per_en   = 1'b1;
        per_we   = we;
        tick();
        per_en = 1'b0;
        per_we = 2'b00;
    endtask

    task automatic wr(input logic [4:0] off, input logic [15:0] d);
        bus_wr(off, d, 2'b11);
    endtask

    task automatic rd_addr(input logic [13:0] a);
        per_addr = a;
        per_en   = 1'b1;
        per_we   = 2'b00;
        #1;
        rd_d   = per_dout;
        rd_d12 = per_dout12;
        per_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] off);
        rd_addr(BASE + 14'(off));
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            rd(5'h0F);
            if (!rd_d[0]) break;
            cnt++;
            tick();
        end
    endtask

    function automatic int sat(longint v);
        if (v > 32767) begin m_ovf = 1'b1; return 32767; end
        if (v < -32768) begin m_ovf = 1'b1; return -32768; end
        return int'(v);
    endfunction

    // Reference: complex products rounded to Q15, then the radix-4 sums.
    function automatic void model();
        longint p [6];
        longint s [8];
        longint xr, xi, wr_, wi, a_r, a_i;
        int sh;
        m_ovf = 1'b0;
        for (int k = 0; k < 3; k++) begin
            xr  = m_op[2+2*k];
            xi  = m_op[3+2*k];
            wr_ = m_tw[2*k];
            wi  = m_tw[2*k+1];
            if (m_tw_en) begin
                p[2*k]   = sat((xr*wr_ - xi*wi + 16384) >>> 15);
                p[2*k+1] = sat((xr*wi + xi*wr_ + 16384) >>> 15);
            end else begin
                p[2*k]   = xr;
                p[2*k+1] = xi;
            end
        end
        sh  = (m_sh == 3) ? 2 : m_sh;
        a_r = m_op[0];
        a_i = m_op[1];
        s[0] = a_r + p[0] + p[2] + p[4];
        s[1] = a_i + p[1] + p[3] + p[5];
        s[2] = a_r + p[1] - p[2] - p[5];
        s[3] = a_i - p[0] - p[3] + p[4];
        s[4] = a_r - p[0] + p[2] - p[4];
        s[5] = a_i - p[1] + p[3] - p[5];
        s[6] = a_r - p[1] - p[2] + p[5];
        s[7] = a_i + p[0] - p[3] - p[4];
        for (int k = 0; k < 8; k++)
            m_x[k] = sat(s[k] >>> sh);
    endfunction

    function automatic logic [15:0] ctrl_word();
        return {11'd0, m_irq_en, 2'(m_sh), m_tw_en, 1'b1};
    endfunction

    task automatic check_results(input string tag);
        model();
        for (int k = 0; k < 8; k++) begin
            rd(5'(16 + k));
            rx[k] = rd_d;
            check($sformatf("%s.x%0d", tag, k), rd_d, 16'(m_x[k]));
        end
        rd(5'h0F);
        check({tag, ".status"}, rd_d, {13'd0, m_ovf, 2'b10});
        check({tag, ".irq"}, {15'd0, irq}, {15'd0, m_irq_en});
    endtask

    task automatic run_op(input string tag);
        int cnt;
        for (int i = 0; i < 8; i++) wr(5'(i), 16'(m_op[i]));
        for (int i = 0; i < 6; i++) wr(5'(8 + i), 16'(m_tw[i]));
        wr(5'h0E, ctrl_word());
        wait_idle(cnt);
        check({tag, ".busy_len"}, 16'(cnt), m_tw_en ? 16'd4 : 16'd1);
        check_results(tag);
        $display("op %s: tw_en=%0d shift=%0d X0=(%0d,%0d) X1=(%0d,%0d) ovf=%0d",
                 tag, m_tw_en, m_sh, m_x[0], m_x[1], m_x[2], m_x[3], m_ovf);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_op[i] = 0;
        for (int k = 0; k < 3; k++) begin
            m_tw[2*k]   = 32767;
            m_tw[2*k+1] = 0;
        end
        m_tw_en  = 1'b0;
        m_irq_en = 1'b0;
        m_sh     = 0;
    endtask

    function automatic int rnd();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 3))
            0:       return 32767;
            1:       return -32768;
            default: return int'($signed(r));
        endcase
    endfunction

    initial begin
        int cnt;
        model_reset();
        repeat (3) @(posedge mclk);
        #20 puc_rst = 1'b0;
        tick();

        // reset state
        rd(5'h00); check("rst.ar", rd_d, 16'h0000);
        rd(5'h08); check("rst.w1r", rd_d, 16'h7FFF);
        rd(5'h09); check("rst.w1i", rd_d, 16'h0000);
        rd(5'h0C); check("rst.w3r", rd_d, 16'h7FFF);
        rd(5'h0E); check("rst.ctrl", rd_d, 16'h0000);
        rd(5'h0F); check("rst.status", rd_d, 16'h0000);
        rd(5'h10); check("rst.x0r", rd_d, 16'h0000);
        check("rst.irq", {15'd0, irq}, 16'h0000);
        check("rst.dout_idle", per_dout, 16'h0000);

        // equal real operands, no twiddles
        for (int i = 0; i < 8; i++) m_op[i] = (i % 2 == 0) ? 1000 : 0;
        run_op("t1");
        check("t1.x0r_abs", rx[0], 16'd4000);

        for (int i = 0; i < 8; i++) m_op[i] = 0;
        m_op[0] = 100;
        m_op[3] = 100;
        run_op("t2");
        check("t2.x0i_abs", rx[1], 16'd100);
        check("t2.x1r_abs", rx[2], 16'd200);
        check("t2.x2i_abs", rx[5], 16'hFF9C);

        // full-scale inputs: saturation, then scaled to fit
        for (int i = 0; i < 8; i++) m_op[i] = (i % 2 == 0) ? 32767 : 0;
        run_op("t3a");
        check("t3a.x0r_abs", rx[0], 16'h7FFF);
        rd(5'h0F); check("t3a.ovf_set", rd_d, 16'h0006);
        wr(5'h0F, 16'h0004);
        rd(5'h0F); check("t3a.ovf_w1c", rd_d, 16'h0002);
        m_sh = 2;
        run_op("t3b");
        check("t3b.x0r_abs", rx[0], 16'h7FFF);
        rd(5'h0F); check("t3b.no_ovf", rd_d, 16'h0002);

        // twiddle j on B with interrupt
        for (int i = 0; i < 8; i++) m_op[i] = 0;
        m_op[2] = 16384;
        m_tw[0] = 0;
        m_tw[1] = 32767;
        m_tw_en = 1'b1;
        m_irq_en = 1'b1;
        m_sh = 0;
        run_op("t4");
        check("t4.x0i_abs", rx[1], 16'd16384);
        check("t4.x1r_abs", rx[2], 16'd16384);
        check("t4.x3r_abs", rx[6], 16'hC000);
        check("t4.irq_abs", {15'd0, irq}, 16'h0001);
        wr(5'h0F, 16'h0002);
        rd(5'h0F); check("t4.done_clr", rd_d, 16'h0000);
        check("t4.irq_clr", {15'd0, irq}, 16'h0000);

        // START rewrite during TW2 is ignored
        wr(5'h0E, ctrl_word());
        wr(5'h18, 16'h0000);
        wr(5'h0E, 16'h0001);
        wait_idle(cnt);
        check("t5a.busy_rest", 16'(cnt), 16'd2);
        check_results("t5a");
        rd(5'h0E); check("t5a.ctrl", rd_d, 16'h0012);
        $display("op t5a: START during TW2, remaining busy=%0d", cnt);

        // operand write during TW2 is ignored
        wr(5'h0E, ctrl_word());
        wr(5'h18, 16'h0000);
        wr(5'h00, 16'h0005);
        wait_idle(cnt);
        check("t5b.busy_rest", 16'(cnt), 16'd2);
        rd(5'h00); check("t5b.ar_kept", rd_d, 16'h0000);
        check_results("t5b");
        $display("op t5b: Ar write during TW2, remaining busy=%0d", cnt);

        // reset during TW2 aborts
        wr(5'h0F, 16'h0002);
        wr(5'h0E, ctrl_word());
        wr(5'h18, 16'h0000);
        puc_rst = 1'b1;
        #1;
        rd(5'h0F); check("t5c.status_rst", rd_d, 16'h0000);
        check("t5c.irq_rst", {15'd0, irq}, 16'h0000);
        rd(5'h08); check("t5c.w1r_rst", rd_d, 16'h7FFF);
        rd(5'h11); check("t5c.x0i_rst", rd_d, 16'h0000);
        #5 puc_rst = 1'b0;
        repeat (6) tick();
        rd(5'h0F); check("t5c.no_done", rd_d, 16'h0000);
        check("t5c.no_irq", {15'd0, irq}, 16'h0000);
        model_reset();
        $display("op t5c: reset pulse during TW2");

        // bus corner cases
        bus_wr(5'h00, 16'h1234, 2'b01);
        rd(5'h00); check("bus.byte_lo", rd_d, 16'h0000);
        bus_wr(5'h00, 16'h1234, 2'b10);
        rd(5'h00); check("bus.byte_hi", rd_d, 16'h0000);
        wr(5'h18, 16'h55AA);
        rd(5'h18); check("bus.off18", rd_d, 16'h0000);
        wr(5'h00, 16'h2222);
        rd(5'h00); check("bus.ar_rw", rd_d, 16'h2222);
        rd_addr(BASE - 14'd1); check("bus.below_span", rd_d, 16'h0000);
        rd_addr(BASE + 14'd32); check("bus.above_span", rd_d, 16'h0000);
        per_addr = BASE;
        per_en = 1'b0;
        #1 check("bus.en_low", per_dout, 16'h0000);
        per_en = 1'b1;
        per_we = 2'b01;
        #1 check("bus.we_nonzero", per_dout, 16'h0000);
        per_en = 1'b0;
        per_we = 2'b00;
        wr(5'h00, 16'h0800);
        rd(5'h00);
        check("bus.dw16_0800", rd_d, 16'h0800);
        check("bus.dw12_signext", rd_d12, 16'hF800);
        $display("op bus: corner cases done");
        m_op[0] = 2048;

        // randomized operations
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 8; i++) m_op[i] = rnd();
            for (int i = 0; i < 6; i++) m_tw[i] = rnd();
            m_tw_en  = 1'($urandom_range(0, 1));
            m_irq_en = 1'($urandom_range(0, 1));
            m_sh     = int'($urandom_range(0, 3));
            run_op($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
